divider: RTL and testbench
==========================

Name: divider

Overview:
- Sequential unsigned restoring divider.
- Companion to the team's shift-add multiplier; uses the same start/busy handshake and the same one-step-per-cycle iterative style.
- Computes quotient and remainder of an N-bit dividend by a D-bit divisor.
- Used by the core's M-extension datapath and by any block needing division without a combinational divider.

Parameters:
- N_W, 16, dividend and quotient width in bits.
- D_W, 8, divisor and remainder width in bits (D_W <= N_W).

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- start_i  input  1  request; sampled only in IDLE.
- a_bi  input  N_W  dividend; sampled when start accepted.
- b_bi  input  D_W  divisor; sampled when start accepted.
- q_bo  output  N_W  quotient, registered.
- r_bo  output  D_W  remainder, registered.
- div_by_zero_o  output  1  high if the last completed operation had divisor 0.
- busy_o  output  1  high while an operation is in progress.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, counter=0, internal regs=0.
  - q_bo=0, r_bo=0, div_by_zero_o=0, busy_o=0, all immediately and independent of the clock.
  - Reset mid-operation aborts the operation; no result is written.
- States: IDLE, WORK. busy_o = (state==WORK).
- IDLE with start_i=1:
  - Latch the dividend into the quotient shift register and the divisor into the divisor register.
  - Clear the partial remainder. ctr=0. Go to WORK.
- WORK with ctr<N_W, one restoring step per cycle:
  - t = {rem, qsh[N_W-1]}, D_W+1 bits.
  - If t >= {1'b0, div}: rem = t - div, qsh = {qsh[N_W-2:0], 1}.
  - Else: rem = t[D_W-1:0], qsh = {qsh[N_W-2:0], 0}.
  - ctr++.
- WORK with ctr==N_W:
  - q_bo <= qsh, r_bo <= rem, div_by_zero_o <= (div==0).
  - Go to IDLE.
- Latency: busy_o is high for exactly N_W+1 cycles (17 at default). Results update on the same edge that busy_o falls.
- Back-to-back: start_i asserted in the first IDLE cycle after completion is accepted, so the minimum issue interval is N_W+2 cycles.
- start_i while busy: ignored, with no queuing. a_bi and b_bi may change freely during WORK.
- Outputs hold their last result until the next completion or reset.
- Divisor 0: no special path; the natural algorithm applies. Result is q_bo = all ones, r_bo = dividend[D_W-1:0], div_by_zero_o=1.
- Divisor > dividend: q_bo=0, r_bo=dividend (fits, since dividend < divisor < 2^D_W).
- Width: the counter is clog2(N_W+1) bits. The D_W+1-bit compare/subtract cannot overflow because rem < div is invariant after each step.

Optional Feature:
- Macro DIVIDER_DONE_PULSE_EN.
- Defined: extra output done_o, 1 bit, reset 0. It pulses high for exactly one cycle, in the cycle after the results update, i.e. the first IDLE cycle after WORK. It is not asserted on reset abort.
- Undefined: port done_o does not exist; all other behaviour is identical.

Decomposition:
- Package divider_pkg:
  - state enum {IDLE, WORK}.
  - Default width constants DIV_N_W=16, DIV_D_W=8.
  - Shared with the multiplier's state localparams where practical.
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: rem, msb-in bit, divisor.
  - Outputs: next rem, quotient bit.
  - Instantiated once in divider; lets the bench check the step exhaustively at D_W=8.

Test Plan:
- a=1000, b=7, start pulse -> busy_o high 17 cycles; then q_bo=142, r_bo=6, div_by_zero_o=0.
- a=0xFFFF, b=0xFF -> q_bo=257, r_bo=0. Then a=5, b=9 -> q_bo=0, r_bo=5.
- a=0x1234, b=0 -> q_bo=0xFFFF, r_bo=0x34, div_by_zero_o=1. Next op a=10, b=3 clears the flag: q=3, r=1, flag=0.
- Start 100/10; pulse start_i with a=7, b=1 and change a_bi/b_bi mid-operation -> result is q=10, r=0, and busy_o stays low after completion (second start ignored).
- Start 1000/7; assert rst_i asynchronously (between edges) at cycle 8 -> busy_o, q_bo, r_bo drop to 0 immediately. After release, 50/7 -> q=7, r=1.
- Random sweep of 1000 operand pairs plus back-to-back starts issued the cycle after busy_o falls -> every result matches a/b and a%b. With DIVIDER_DONE_PULSE_EN, done_o is a single-cycle pulse per operation.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package divider_pkg;

    localparam int unsigned DIV_N_W = 16;
    localparam int unsigned DIV_D_W = 8;

    typedef enum logic {
        IDLE,
        WORK
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to subtract the divisor.
module div_step
    import divider_pkg::*;
#(
    parameter int unsigned D_W = DIV_D_W
) (
    input  logic [D_W-1:0] rem,
    input  logic           msb,
    input  logic [D_W-1:0] div,
    output logic [D_W-1:0] rem_next,
    output logic           q_bit
);

    logic [D_W:0]   trial;
    logic [D_W-1:0] diff;

    always_comb begin
        trial    = {rem, msb};
        // The low bits of the full-width difference equal the truncated difference.
        diff     = trial[D_W-1:0] - div;
        q_bit    = (trial >= {1'b0, div});
        rem_next = q_bit ? diff : trial[D_W-1:0];
    end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle with a start/busy handshake.
// Optional done_o completion pulse when DIVIDER_DONE_PULSE_EN is defined.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned N_W = DIV_N_W,
    parameter int unsigned D_W = DIV_D_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [N_W-1:0] a_bi,
    input  logic [D_W-1:0] b_bi,
    output logic [N_W-1:0] q_bo,
    output logic [D_W-1:0] r_bo,
    output logic           div_by_zero_o,
    output logic           busy_o
`ifdef DIVIDER_DONE_PULSE_EN
    ,
    output logic           done_o
`endif
);

    localparam int unsigned CTR_W = $clog2(N_W + 1);

    state_t         state, state_next;
    logic [CTR_W-1:0] ctr, ctr_next;
    logic [N_W-1:0] qsh, qsh_next;
    logic [D_W-1:0] rem, rem_next;
    logic [D_W-1:0] div, div_next;
    logic [N_W-1:0] q_next;
    logic [D_W-1:0] r_next;
    logic           dbz_next;
    logic [D_W-1:0] step_rem;
    logic           step_q;
`ifdef DIVIDER_DONE_PULSE_EN
    logic           fin;
`endif

    div_step #(.D_W(D_W)) u_step (
        .rem      (rem),
        .msb      (qsh[N_W-1]),
        .div      (div),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        state_next = state;
        ctr_next   = ctr;
        qsh_next   = qsh;
        rem_next   = rem;
        div_next   = div;
        q_next     = q_bo;
        r_next     = r_bo;
        dbz_next   = div_by_zero_o;
`ifdef DIVIDER_DONE_PULSE_EN
        fin        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_i) begin
                    qsh_next   = a_bi;
                    div_next   = b_bi;
                    rem_next   = '0;
                    ctr_next   = '0;
                    state_next = WORK;
                end
            end
            WORK: begin
                if (ctr != CTR_W'(N_W)) begin
                    rem_next = step_rem;
                    qsh_next = {qsh[N_W-2:0], step_q};
                    ctr_next = ctr + 1'b1;
                end else begin
                    q_next     = qsh;
                    r_next     = rem;
                    dbz_next   = (div == '0);
                    state_next = IDLE;
`ifdef DIVIDER_DONE_PULSE_EN
                    fin        = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            ctr           <= '0;
            qsh           <= '0;
            rem           <= '0;
            div           <= '0;
            q_bo          <= '0;
            r_bo          <= '0;
            div_by_zero_o <= 1'b0;
`ifdef DIVIDER_DONE_PULSE_EN
            done_o        <= 1'b0;
`endif
        end else begin
            state         <= state_next;
            ctr           <= ctr_next;
            qsh           <= qsh_next;
            rem           <= rem_next;
            div           <= div_next;
            q_bo          <= q_next;
            r_bo          <= r_next;
            div_by_zero_o <= dbz_next;
`ifdef DIVIDER_DONE_PULSE_EN
            done_o        <= fin;
`endif
        end
    end

    assign busy_o = (state == WORK);

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider (default 16/8 widths) and its div_step sub-module.
module tb_divider;
    import divider_pkg::*;

    localparam int unsigned N_W = 16;
    localparam int unsigned D_W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N_W-1:0] a;
    logic [D_W-1:0] b;
    logic [N_W-1:0] q;
    logic [D_W-1:0] r;
    logic           dbz;
    logic           busy;
`ifdef DIVIDER_DONE_PULSE_EN
    logic           done;
`endif

    logic [7:0] s_rem, s_div, s_rn;
    logic       s_msb, s_q;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    divider #(.N_W(N_W), .D_W(D_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .a_bi          (a),
        .b_bi          (b),
        .q_bo          (q),
        .r_bo          (r),
        .div_by_zero_o (dbz),
        .busy_o        (busy)
`ifdef DIVIDER_DONE_PULSE_EN
        ,
        .done_o        (done)
`endif
    );

    div_step #(.D_W(8)) step_dut (
        .rem      (s_rem),
        .msb      (s_msb),
        .div      (s_div),
        .rem_next (s_rn),
        .q_bit    (s_q)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the accept edge.
    task automatic launch(input logic [N_W-1:0] av, input logic [D_W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int pre, input logic [N_W-1:0] eq,
                             input logic [D_W-1:0] er, input logic ez);
        int cnt;
        cnt = pre;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check({tag, " busy_cycles"}, cnt, 17);
        check({tag, " q"}, q, eq);
        check({tag, " r"}, r, er);
        check({tag, " dbz"}, dbz, ez);
`ifdef DIVIDER_DONE_PULSE_EN
        check({tag, " done"}, done, 1'b1);
`endif
    endtask

    initial begin
        int unsigned av, bv, t;
        logic [N_W-1:0] eq;
        logic [D_W-1:0] er;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        s_rem = '0;
        s_msb = 1'b0;
        s_div = '0;
        #1;
        check("reset busy", busy, 1'b0);
        check("reset q", q, 16'h0);
        check("reset r", r, 8'h0);
        check("reset dbz", dbz, 1'b0);
`ifdef DIVIDER_DONE_PULSE_EN
        check("reset done", done, 1'b0);
`endif

        // Exhaustive single step over all reachable (rem < div, or div == 0) inputs.
        for (int d = 0; d < 256; d++) begin
            for (int rr = 0; rr < ((d == 0) ? 256 : d); rr++) begin
                for (int m = 0; m < 2; m++) begin
                    s_div = 8'(d);
                    s_rem = 8'(rr);
                    s_msb = 1'(m);
                    #1;
                    t = 32'(rr * 2 + m);
                    if (t >= 32'(d)) check("step", {s_q, s_rn}, {1'b1, 8'(t - 32'(d))});
                    else             check("step", {s_q, s_rn}, {1'b0, 8'(t)});
                end
            end
        end

        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle busy", busy, 1'b0);

        launch(16'd1000, 8'd7);
        finish_op("1000/7", 0, 16'd142, 8'd6, 1'b0);

        launch(16'hFFFF, 8'hFF);
        finish_op("ffff/ff", 0, 16'd257, 8'd0, 1'b0);
        launch(16'd5, 8'd9);
        finish_op("5/9", 0, 16'd0, 8'd5, 1'b0);

        launch(16'h1234, 8'd0);
        finish_op("1234/0", 0, 16'hFFFF, 8'h34, 1'b1);
        launch(16'd10, 8'd3);
        finish_op("10/3", 0, 16'd3, 8'd1, 1'b0);
        @(posedge clk);
        #1;
`ifdef DIVIDER_DONE_PULSE_EN
        check("done single pulse", done, 1'b0);
`endif
        check("idle after 10/3", busy, 1'b0);

        // Start while busy must be ignored and operand changes must not disturb the result.
        launch(16'd100, 8'd10);
        start = 1'b1;
        a     = 16'd7;
        b     = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'hBEEF;
        b     = 8'h55;
        finish_op("100/10 ignore", 1, 16'd10, 8'd0, 1'b0);
        @(posedge clk);
        #1;
        check("no queued start", busy, 1'b0);
        check("hold q", q, 16'd10);

        launch(16'd1000, 8'd7);
        repeat (7) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort q", q, 16'd0);
        check("abort r", r, 8'd0);
        check("abort dbz", dbz, 1'b0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort idle", busy, 1'b0);
        check("abort no result", q, 16'd0);
`ifdef DIVIDER_DONE_PULSE_EN
        check("abort no done", done, 1'b0);
`endif
        launch(16'd50, 8'd7);
        finish_op("50/7", 0, 16'd7, 8'd1, 1'b0);

        // Back-to-back random operations, each issued in the first IDLE cycle.
        for (int i = 0; i < 1000; i++) begin
            av = $urandom_range(0, 65535);
            bv = (i % 16 == 0) ? 0 : $urandom_range(0, 255);
            if (bv == 0) begin
                eq = 16'hFFFF;
                er = 8'(av);
            end else begin
                eq = 16'(av / bv);
                er = 8'(av % bv);
            end
            launch(16'(av), 8'(bv));
            finish_op("random", 0, eq, er, (bv == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
